// File: rtl/obuf_writeback_fifo_if.sv
`default_nettype none
// ============================================================================
// obuf_writeback_fifo_if: array write stream in, output-buffer write port out.
// Rev 1.0
// ============================================================================
interface obuf_writeback_fifo_if #(
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int OUT_WIDTH       = 192
);
  logic                       sa_write_req;
  logic [OBUF_ADDR_WIDTH-1:0] sa_write_addr;
  logic [OUT_WIDTH-1:0]       sa_write_data;
  logic                       mem_write_req;
  logic [OBUF_ADDR_WIDTH-1:0] mem_write_addr;
  logic [OUT_WIDTH-1:0]       mem_write_data;
  logic                       mem_write_ready;

  modport master (
    output sa_write_req, sa_write_addr, sa_write_data, mem_write_ready,
    input  mem_write_req, mem_write_addr, mem_write_data
  );

  modport slave (
    input  sa_write_req, sa_write_addr, sa_write_data, mem_write_ready,
    output mem_write_req, mem_write_addr, mem_write_data
  );
endinterface
`default_nettype wire

// File: rtl/obuf_writeback_fifo.sv
`default_nettype none
// ============================================================================
// obuf_writeback_fifo: systolic-array output-buffer write-back FIFO, drain FSM.
// Optional macro OBUF_WB_ADDR_CHECK_EN enables address-sequence checking. Rev 1.0
// ============================================================================
module obuf_writeback_fifo #(
  parameter int ARRAY_M         = 4,
  parameter int ACC_WIDTH       = 48,
  parameter int OUT_WIDTH       = ARRAY_M * ACC_WIDTH,
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int DEPTH           = 8,
  parameter int STALL_MARGIN    = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  obuf_writeback_fifo_if.slave       bus,
  input  wire logic                  drain_req,
  output logic                       stall,
  output logic                       overflow,
  output logic                       addr_err,
  output logic                       drain_done,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MARGIN = CNT_W'(STALL_MARGIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [OBUF_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [OUT_WIDTH-1:0]       data_mem [DEPTH];

  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           rd_ptr_next;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_after_pop;
  logic [CNT_W-1:0]           count_next;
  logic                       head_valid;
  logic [OBUF_ADDR_WIDTH-1:0] head_addr;
  logic [OUT_WIDTH-1:0]       head_data;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       drain_finish;
  state_t                     state;

  assign full            = (count == FULL);
  assign pop             = head_valid && bus.mem_write_ready;
  assign push            = bus.sa_write_req && (!full || pop);
  assign count_after_pop = count - CNT_W'(pop);
  assign count_next      = count_after_pop + CNT_W'(push);
  assign rd_ptr_next     = rd_ptr + PTR_W'(pop);
  assign drain_finish    = (state == DRAIN) && (count_next == '0) && !push;

  // Request is masked during reset so no write escapes in the reset cycle.
  assign bus.mem_write_req  = head_valid && !reset;
  assign bus.mem_write_addr = head_addr;
  assign bus.mem_write_data = head_data;
  assign fifo_count         = count;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.sa_write_addr;
      data_mem[wr_ptr] <= bus.sa_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      stall  <= ((FULL - count_next) <= MARGIN);
      if (bus.sa_write_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head register: when the FIFO is otherwise empty the incoming push
  // becomes the head directly, bypassing the storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid <= 1'b0;
      head_addr  <= '0;
      head_data  <= '0;
    end else begin
      head_valid <= (count_next != '0);
      if (count_after_pop == '0) begin
        if (push) begin
          head_addr <= bus.sa_write_addr;
          head_data <= bus.sa_write_data;
        end
      end else if (pop) begin
        head_addr <= addr_mem[rd_ptr_next];
        head_data <= data_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_finish) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef OBUF_WB_ADDR_CHECK_EN
  logic [OBUF_ADDR_WIDTH-1:0] prev_addr;
  logic [OBUF_ADDR_WIDTH-1:0] prev_addr_inc;
  logic                       prev_valid;

  assign prev_addr_inc = prev_addr + OBUF_ADDR_WIDTH'(1);

  // History is forgotten at end of tile so the next tile may start anywhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr  <= '0;
      prev_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (push) begin
      if (prev_valid && (bus.sa_write_addr != prev_addr) &&
          (bus.sa_write_addr != prev_addr_inc)) begin
        addr_err <= 1'b1;
      end
      prev_addr  <= bus.sa_write_addr;
      prev_valid <= 1'b1;
    end else if (drain_finish) begin
      prev_valid <= 1'b0;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obuf_writeback_fifo.sv
`default_nettype none
// tb_obuf_writeback_fifo: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_obuf_writeback_fifo;
  localparam int ARRAY_M      = 4;
  localparam int ACC_WIDTH    = 48;
  localparam int OUT_WIDTH    = ARRAY_M * ACC_WIDTH;
  localparam int AW           = 16;
  localparam int DEPTH        = 8;
  localparam int STALL_MARGIN = 2;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          drain_req = 1'b0;
  logic          stall, overflow, addr_err, drain_done;
  logic [CW-1:0] fifo_count;

  obuf_writeback_fifo_if #(.OBUF_ADDR_WIDTH(AW), .OUT_WIDTH(OUT_WIDTH)) wb_if ();

  obuf_writeback_fifo #(
    .ARRAY_M(ARRAY_M), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .OBUF_ADDR_WIDTH(AW), .DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .bus(wb_if), .drain_req(drain_req),
    .stall(stall), .overflow(overflow), .addr_err(addr_err),
    .drain_done(drain_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;

  typedef struct {
    logic [AW-1:0]        a;
    logic [OUT_WIDTH-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_ovf, m_stall, m_done, m_aerr, m_pv;
  logic [AW-1:0] m_pa;
  int            m_st;

  typedef struct {
    bit            rst, wreq;
    logic [AW-1:0] a;
    bit            rdy;
    int            cnt;
    bit            req;
    logic [AW-1:0] ha;
    bit            stl, ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [OUT_WIDTH-1:0] mkdata(input logic [AW-1:0] a);
    return {ARRAY_M{32'h0000_4321, a}};
  endfunction

  function automatic void add(input bit rst, wreq, input int a, input bit rdy,
                              input int cnt, input bit req, input int ha,
                              input bit stl, ovf);
    vec_t v;
    v.rst = rst; v.wreq = wreq; v.a = AW'(a); v.rdy = rdy;
    v.cnt = cnt; v.req = req; v.ha = AW'(ha); v.stl = stl; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, wreq, input logic [AW-1:0] a,
                            input logic [OUT_WIDTH-1:0] d, input bit rdy, drn);
    bit   pop, push;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_stall = 0; m_done = 0; m_aerr = 0; m_pv = 0; m_pa = '0; m_st = 0;
      return;
    end
    pop  = (mq.size() != 0) && rdy;
    push = wreq && ((mq.size() < DEPTH) || pop);
    if (wreq && !push) m_ovf = 1;
`ifdef OBUF_WB_ADDR_CHECK_EN
    if (push) begin
      if (m_pv && (a != m_pa) && (a != AW'(m_pa + 1))) m_aerr = 1;
      m_pa = a;
      m_pv = 1;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.a = a; e.d = d;
      mq.push_back(e);
    end
    m_stall = (DEPTH - mq.size()) <= STALL_MARGIN;
    m_done = 0;
    case (m_st)
      0: if (drn) m_st = 1;
      1: if ((mq.size() == 0) && !push) begin m_st = 2; m_done = 1; m_pv = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, fifo_count, mq.size());
    chk({tag, " req"}, wb_if.mem_write_req, mq.size() != 0);
    if (mq.size() != 0) begin
      chk({tag, " addr"}, wb_if.mem_write_addr, mq[0].a);
      chk({tag, " data"}, wb_if.mem_write_data, mq[0].d);
    end
    chk({tag, " stall"}, stall, m_stall);
    chk({tag, " overflow"}, overflow, m_ovf);
    chk({tag, " addr_err"}, addr_err, m_aerr);
    chk({tag, " drain_done"}, drain_done, m_done);
  endtask

  // Called at the falling edge: drive, let one rising edge pass, check.
  task automatic step(input string tag, input bit rst, wreq, input logic [AW-1:0] a,
                      input logic [OUT_WIDTH-1:0] d, input bit rdy, drn);
    reset = rst; wb_if.sa_write_req = wreq; wb_if.sa_write_addr = a;
    wb_if.sa_write_data = d; wb_if.mem_write_ready = rdy; drain_req = drn;
    #1;
    if (rst) chk({tag, " no_write_in_reset"}, wb_if.mem_write_req, 0);
    if (wb_if.mem_write_req && rdy) writes++;
    @(posedge clk);
    model_step(rst, wreq, a, d, rdy, drn);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [OUT_WIDTH-1:0] dval;
    logic [AW-1:0]        ra;
    int                   pulses, pulse_at;

    wb_if.sa_write_req = 0; wb_if.sa_write_addr = '0;
    wb_if.sa_write_data = '0; wb_if.mem_write_ready = 0;

    // Reset, fill to full with ready low, overflow, then drain in order.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, i, 0, i + 1, 1, 0, (i + 1) >= 6, 0);
    add(0, 1, 8, 0, 8, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 7 - i, i < 7, i + 1, (7 - i) >= 6, 1);
    // Full with simultaneous push and pop: accepted, no overflow.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, i, 0, i + 1, 1, 0, (i + 1) >= 6, 0);
    add(0, 1, 8, 1, 8, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 7 - i, i < 7, i + 2, (7 - i) >= 6, 0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; wb_if.sa_write_req = tbl[i].wreq;
      wb_if.sa_write_addr = tbl[i].a; wb_if.sa_write_data = mkdata(tbl[i].a);
      wb_if.mem_write_ready = tbl[i].rdy; drain_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d count", i), fifo_count, tbl[i].cnt);
      chk($sformatf("tbl%0d req", i), wb_if.mem_write_req, tbl[i].req);
      if (tbl[i].req || tbl[i].rst) begin
        chk($sformatf("tbl%0d addr", i), wb_if.mem_write_addr, tbl[i].ha);
        chk($sformatf("tbl%0d data", i), wb_if.mem_write_data,
            tbl[i].rst ? '0 : mkdata(tbl[i].ha));
      end
      chk($sformatf("tbl%0d stall", i), stall, tbl[i].stl);
      chk($sformatf("tbl%0d overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d drain_done", i), drain_done, 0);
      chk($sformatf("tbl%0d addr_err", i), addr_err, 0);
    end

    // Single push with ready high: one-cycle request carrying the pushed beat.
    step("rst", 1, 0, '0, '0, 0, 0);
    dval = {ARRAY_M{48'h0000_4321_1234}};
    step("single", 0, 1, 16'h0010, dval, 1, 0);
    chk("single req", wb_if.mem_write_req, 1);
    chk("single addr", wb_if.mem_write_addr, 16'h0010);
    chk("single data", wb_if.mem_write_data, dval);
    step("single_pop", 0, 0, '0, '0, 1, 0);
    chk("single req_off", wb_if.mem_write_req, 0);
    chk("single count", fifo_count, 0);

    // Drain of four entries with ready toggling, drain_req repeated in DRAIN.
    for (int i = 0; i < 4; i++) step("dr_fill", 0, 1, AW'(i), mkdata(AW'(i)), 0, 0);
    writes = 0; pulses = 0; pulse_at = -1;
    for (int k = 0; k < 16; k++) begin
      step("drain", 0, 0, '0, '0, (k % 2) == 0, k < 3);
      if (drain_done) begin pulses++; pulse_at = k; end
    end
    chk("drain writes", writes, 4);
    chk("drain pulses", pulses, 1);
    chk("drain pulse_cycle", pulse_at, 6);

    // Drain of an already empty FIFO: done two cycles after the request.
    step("de_req", 0, 0, '0, '0, 0, 1);
    chk("empty_drain t1", drain_done, 0);
    step("de_t2", 0, 0, '0, '0, 0, 0);
    chk("empty_drain t2", drain_done, 1);
    step("de_t3", 0, 0, '0, '0, 0, 0);
    chk("empty_drain t3", drain_done, 0);

    // Overflow, partial drain to five entries, then reset mid-operation.
    for (int i = 0; i < 9; i++) step("rs_fill", 0, 1, AW'(i), mkdata(AW'(i)), 0, 0);
    for (int i = 0; i < 3; i++) step("rs_pop", 0, 0, '0, '0, 1, 0);
    chk("pre_reset count", fifo_count, 5);
    chk("pre_reset overflow", overflow, 1);
    step("mid_reset", 1, 0, '0, '0, 1, 0);
    chk("mid_reset count", fifo_count, 0);
    chk("mid_reset req", wb_if.mem_write_req, 0);
    chk("mid_reset overflow", overflow, 0);

    // Address sequence 4,5,5,7: only the jump to 7 is illegal.
    step("ac0", 0, 1, 16'd4, mkdata(16'd4), 1, 0);
    step("ac1", 0, 1, 16'd5, mkdata(16'd5), 1, 0);
    step("ac2", 0, 1, 16'd5, mkdata(16'd5), 1, 0);
    chk("addr_chk before", addr_err, 0);
    step("ac3", 0, 1, 16'd7, mkdata(16'd7), 1, 0);
`ifdef OBUF_WB_ADDR_CHECK_EN
    chk("addr_chk after", addr_err, 1);
`else
    chk("addr_chk after", addr_err, 0);
`endif

    // Randomized traffic against the reference model.
    step("rnd_rst", 1, 0, '0, '0, 0, 0);
    ra = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) ra = AW'($urandom);
      else ra = ra + AW'($urandom_range(0, 1));
      step("rnd", $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, ra,
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
